// File: rtl/home_pkg.sv
// Shared definitions for the home automation sequencer: alarm and fan state
// encodings plus the default tick counts used by the top-level parameters.
package home_pkg;

  localparam int DEF_LIGHT_HOLD  = 3;
  localparam int DEF_FAN_MIN_ON  = 4;
  localparam int DEF_FAN_MIN_OFF = 2;
  localparam int DEF_EXIT_TICKS  = 2;
  localparam int DEF_ENTRY_TICKS = 3;
  localparam int DEF_CNT_W       = 8;

  // The alarm encoding is visible on alarm_state, so the values are pinned.
  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    EXIT     = 3'd1,
    ARMED    = 3'd2,
    ENTRY    = 3'd3,
    ALARM    = 3'd4
  } alarm_e;

  typedef enum logic {
    FAN_OFF = 1'b0,
    FAN_ON  = 1'b1
  } fan_e;

endpackage

// File: rtl/tick_timer.sv
// Loadable down counter advanced by the timebase tick; stops at zero.
// Priority: clear, then load, then tick-driven decrement.
module tick_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/home_sequencer.sv
// Light hold timer, fan dwell FSM and alarm arming FSM for the home actuators.
// Every output is decoded from a register; inputs reach outputs after one clock.
module home_sequencer
  import home_pkg::*;
#(
  parameter int LIGHT_HOLD  = DEF_LIGHT_HOLD,
  parameter int FAN_MIN_ON  = DEF_FAN_MIN_ON,
  parameter int FAN_MIN_OFF = DEF_FAN_MIN_OFF,
  parameter int EXIT_TICKS  = DEF_EXIT_TICKS,
  parameter int ENTRY_TICKS = DEF_ENTRY_TICKS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       pir,
  input  logic       is_dark,
  input  logic       temp_high,
  input  logic       authorized,
  output logic       light_on,
  output logic       fan_on,
  output logic       alarm_on,
  output logic [2:0] alarm_state
);

  localparam logic [CNT_W-1:0] LIGHT_LOAD   = CNT_W'(LIGHT_HOLD);
  localparam logic [CNT_W-1:0] FAN_ON_LOAD  = CNT_W'(FAN_MIN_ON);
  localparam logic [CNT_W-1:0] FAN_OFF_LOAD = CNT_W'(FAN_MIN_OFF);
  localparam logic [CNT_W-1:0] EXIT_LAST    = CNT_W'(EXIT_TICKS - 1);
  localparam logic [CNT_W-1:0] ENTRY_LAST   = CNT_W'(ENTRY_TICKS - 1);

  // ---------------------------------------------------------------- light
  logic light_clr;
  logic light_zero;

  assign light_clr = !is_dark;

  tick_timer #(.CNT_W(CNT_W)) u_light_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .clr      (light_clr),
    .load     (pir),
    .load_val (LIGHT_LOAD),
    .zero     (light_zero)
  );

  // ---------------------------------------------------------------- fan
  fan_e             fan_st;
  logic             fan_zero;
  logic             fan_start;
  logic             fan_stop;
  logic             fan_load;
  logic [CNT_W-1:0] fan_load_val;

  // Direction changes only once the dwell from the previous change expired.
  always_comb begin
    fan_start    = (fan_st == FAN_OFF) && temp_high && fan_zero;
    fan_stop     = (fan_st == FAN_ON) && !temp_high && fan_zero;
    fan_load     = fan_start || fan_stop;
    fan_load_val = fan_start ? FAN_ON_LOAD : FAN_OFF_LOAD;
  end

  tick_timer #(.CNT_W(CNT_W)) u_fan_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .clr      (1'b0),
    .load     (fan_load),
    .load_val (fan_load_val),
    .zero     (fan_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fan_st <= FAN_OFF;
    end else if (fan_start) begin
      fan_st <= FAN_ON;
    end else if (fan_stop) begin
      fan_st <= FAN_OFF;
    end
  end

  // ---------------------------------------------------------------- alarm
  alarm_e           alarm_st;
  logic [CNT_W-1:0] acnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_st <= DISARMED;
      acnt     <= '0;
    end else if (authorized) begin
      alarm_st <= DISARMED;
      acnt     <= '0;
    end else begin
      case (alarm_st)
        DISARMED: begin
          alarm_st <= EXIT;
          acnt     <= '0;
        end
        EXIT: begin
          // Motion is deliberately ignored while the occupant is leaving.
          if (tick) begin
            if (acnt == EXIT_LAST) begin
              alarm_st <= ARMED;
              acnt     <= '0;
            end else begin
              acnt <= acnt + 1'b1;
            end
          end
        end
        ARMED: begin
          if (pir) begin
            alarm_st <= ENTRY;
            acnt     <= '0;
          end
        end
        ENTRY: begin
          if (tick) begin
            if (acnt == ENTRY_LAST) begin
              alarm_st <= ALARM;
              acnt     <= '0;
            end else begin
              acnt <= acnt + 1'b1;
            end
          end
        end
        ALARM: begin
          alarm_st <= ALARM;
        end
        // NOTE: the unused encodings 5-7 land here and recover to DISARMED.
        default: begin
          alarm_st <= DISARMED;
          acnt     <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  assign light_on    = !light_zero;
  assign fan_on      = (fan_st == FAN_ON);
  assign alarm_on    = (alarm_st == ALARM);
  assign alarm_state = alarm_st;

endmodule

// File: tb/tb_home_sequencer.sv
// Self-checking bench for home_sequencer: vector table, hand-written corner
// sequences and randomized traffic against a behavioural reference model.
module tb_home_sequencer;
  import home_pkg::*;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       tick       = 1'b0;
  logic       pir        = 1'b0;
  logic       is_dark    = 1'b0;
  logic       temp_high  = 1'b0;
  logic       authorized = 1'b1;
  logic       light_on;
  logic       fan_on;
  logic       alarm_on;
  logic [2:0] alarm_state;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  home_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .pir         (pir),
    .is_dark     (is_dark),
    .temp_high   (temp_high),
    .authorized  (authorized),
    .light_on    (light_on),
    .fan_on      (fan_on),
    .alarm_on    (alarm_on),
    .alarm_state (alarm_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: counters as plain integers, rules applied in priority order.
  int m_light, m_fcnt, m_acnt, m_state;
  bit m_fan;

  task automatic model_reset();
    m_light = 0; m_fcnt = 0; m_acnt = 0; m_state = 0; m_fan = 0;
  endtask

  task automatic model_step();
    if (!is_dark)                   m_light = 0;
    else if (pir)                   m_light = DEF_LIGHT_HOLD;
    else if (tick && m_light > 0)   m_light = m_light - 1;

    if (!m_fan && temp_high && m_fcnt == 0) begin
      m_fan = 1; m_fcnt = DEF_FAN_MIN_ON;
    end else if (m_fan && !temp_high && m_fcnt == 0) begin
      m_fan = 0; m_fcnt = DEF_FAN_MIN_OFF;
    end else if (tick && m_fcnt > 0) begin
      m_fcnt = m_fcnt - 1;
    end

    if (authorized) begin
      m_state = 0; m_acnt = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_acnt = 0;
    end else if (m_state == 1 && tick) begin
      if (m_acnt + 1 == DEF_EXIT_TICKS) begin m_state = 2; m_acnt = 0; end
      else m_acnt++;
    end else if (m_state == 2 && pir) begin
      m_state = 3; m_acnt = 0;
    end else if (m_state == 3 && tick) begin
      if (m_acnt + 1 == DEF_ENTRY_TICKS) begin m_state = 4; m_acnt = 0; end
      else m_acnt++;
    end
  endtask

  function automatic logic [5:0] model_out();
    logic [2:0] st;
    st = 3'(m_state);
    return {m_light != 0, m_fan, m_state == 4, st};
  endfunction

  function automatic logic [5:0] dut_out();
    return {light_on, fan_on, alarm_on, alarm_state};
  endfunction

  // One clock: inputs already driven after a falling edge, outputs sampled
  // on the following falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    int         n;
    logic       tk, pr, dk, th, au;
    logic       el, ef, ea;
    logic [2:0] es;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic tk, input logic pr, input logic dk,
                     input logic th, input logic au, input logic el, input logic ef,
                     input logic ea, input logic [2:0] es);
    vec_t v;
    v.n = n; v.tk = tk; v.pr = pr; v.dk = dk; v.th = th; v.au = au;
    v.el = el; v.ef = ef; v.ea = ea; v.es = es;
    vecs.push_back(v);
  endtask

  // Three idle clocks then one tick clock, repeated.
  task automatic tick_periods(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b0; repeat (3) step();
      tick = 1'b1; step();
      tick = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int first_alarm;
    model_reset();

    // ---------------- reset values
    repeat (2) @(negedge clk);
    check("rst_light", light_on, 0);
    check("rst_fan", fan_on, 0);
    check("rst_alarm_on", alarm_on, 0);
    check("rst_state", alarm_state, 0);
    rst_n = 1'b1;

    // ---------------- vector table: n, tick pir dark temp auth -> light fan alarm state
    // Light hold and retrigger, then darkness ending.
    add(1, 0,1,1,0,1, 1,0,0,0);
    add(2, 0,0,1,0,1, 1,0,0,0);
    add(1, 1,0,1,0,1, 1,0,0,0);
    add(3, 0,0,1,0,1, 1,0,0,0);
    add(1, 1,0,1,0,1, 1,0,0,0);
    add(3, 0,0,1,0,1, 1,0,0,0);
    add(1, 1,0,1,0,1, 0,0,0,0);
    add(1, 0,1,1,0,1, 1,0,0,0);
    add(2, 0,0,1,0,1, 1,0,0,0);
    add(1, 1,0,1,0,1, 1,0,0,0);
    add(1, 0,1,1,0,1, 1,0,0,0);
    add(2, 0,0,1,0,1, 1,0,0,0);
    add(1, 1,0,1,0,1, 1,0,0,0);
    add(3, 0,0,1,0,1, 1,0,0,0);
    add(1, 1,0,1,0,1, 1,0,0,0);
    add(3, 0,0,1,0,1, 1,0,0,0);
    add(1, 1,0,1,0,1, 0,0,0,0);
    add(1, 0,1,1,0,1, 1,0,0,0);
    add(1, 0,0,0,0,1, 0,0,0,0);
    // Arming with motion ignored in EXIT, entry delay, latched alarm, disarm.
    add(1, 0,0,0,0,0, 0,0,0,1);
    add(2, 0,1,0,0,0, 0,0,0,1);
    add(1, 1,1,0,0,0, 0,0,0,1);
    add(3, 0,1,0,0,0, 0,0,0,1);
    add(1, 1,0,0,0,0, 0,0,0,2);
    add(2, 0,0,0,0,0, 0,0,0,2);
    add(1, 0,1,0,0,0, 0,0,0,3);
    add(1, 1,0,0,0,0, 0,0,0,3);
    add(3, 0,0,0,0,0, 0,0,0,3);
    add(1, 1,0,0,0,0, 0,0,0,3);
    add(3, 0,0,0,0,0, 0,0,0,3);
    add(1, 1,0,0,0,0, 0,0,1,4);
    add(3, 0,0,0,0,0, 0,0,1,4);
    add(1, 1,1,0,0,0, 0,0,1,4);
    add(1, 0,0,0,0,1, 0,0,0,0);
    // Entry abort two ticks in, on the very tick that would otherwise alarm.
    add(1, 0,0,0,0,0, 0,0,0,1);
    add(1, 1,0,0,0,0, 0,0,0,1);
    add(1, 0,0,0,0,0, 0,0,0,1);
    add(1, 1,0,0,0,0, 0,0,0,2);
    add(1, 0,1,0,0,0, 0,0,0,3);
    add(1, 1,0,0,0,0, 0,0,0,3);
    add(1, 0,0,0,0,0, 0,0,0,3);
    add(1, 1,0,0,0,0, 0,0,0,3);
    add(1, 1,0,0,0,1, 0,0,0,0);
    add(3, 0,0,0,0,1, 0,0,0,0);
    // Fan minimum on time, then minimum off time before restart.
    add(1, 0,0,0,1,1, 0,1,0,0);
    add(2, 0,0,0,1,1, 0,1,0,0);
    add(1, 1,0,0,0,1, 0,1,0,0);
    add(3, 0,0,0,0,1, 0,1,0,0);
    add(1, 1,0,0,0,1, 0,1,0,0);
    add(3, 0,0,0,0,1, 0,1,0,0);
    add(1, 1,0,0,0,1, 0,1,0,0);
    add(3, 0,0,0,0,1, 0,1,0,0);
    add(1, 1,0,0,0,1, 0,1,0,0);
    add(1, 0,0,0,0,1, 0,0,0,0);
    add(2, 0,0,0,1,1, 0,0,0,0);
    add(1, 1,0,0,1,1, 0,0,0,0);
    add(3, 0,0,0,1,1, 0,0,0,0);
    add(1, 1,0,0,1,1, 0,0,0,0);
    add(1, 0,0,0,1,1, 0,1,0,0);

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        tick = vecs[i].tk; pir = vecs[i].pr; is_dark = vecs[i].dk;
        temp_high = vecs[i].th; authorized = vecs[i].au;
        step();
        check($sformatf("vec%0d_%0d", i, k), dut_out(),
              {vecs[i].el, vecs[i].ef, vecs[i].ea, vecs[i].es});
      end
    end

    // ---------------- reset in the middle of ALARM
    tick = 0; pir = 0; is_dark = 0; temp_high = 0; authorized = 0;
    step();
    tick_periods(2);
    pir = 1; step(); pir = 0;
    tick_periods(3);
    check("reach_alarm", {alarm_on, alarm_state}, {1'b1, 3'd4});
    #2 rst_n = 1'b0;
    #1 check("async_rst_outputs", dut_out(), 6'd0);
    pir = 1; authorized = 0; tick = 0; temp_high = 0; is_dark = 0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    first_alarm = -1;
    for (int c = 0; c < 24; c++) begin
      tick = ((c % 4) == 3);
      step();
      if (c == 0) check("exit_after_reset", alarm_state, 3'd1);
      check($sformatf("post_rst_c%0d", c), dut_out(), model_out());
      if (alarm_on && first_alarm < 0) first_alarm = c;
    end
    check("first_alarm_cycle", first_alarm, 19);

    // ---------------- illegal encoding recovery
    tick = 0; pir = 0; authorized = 1;
    step();
    check("disarmed_before_force", alarm_state, 3'd0);
    authorized = 0;
    force dut.alarm_st = alarm_e'(3'd5);
    #1 release dut.alarm_st;
    step();
    check("illegal_recover", alarm_state, 3'd0);
    step();
    check("illegal_then_exit", alarm_state, 3'd1);

    // ---------------- randomized traffic against the model
    rst_n = 1'b0;
    authorized = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      tick    = ((c % 4) == 3);
      pir     = ($urandom_range(0, 5) == 0);
      is_dark = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 11) == 0) temp_high  = ~temp_high;
      if ($urandom_range(0, 39) == 0) authorized = ~authorized;
      step();
      check($sformatf("rand_c%0d", c), dut_out(), model_out());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/home_sequencer.md
# home_sequencer

Sequential controller for the home automation outputs: light, fan and intrusion alarm. It replaces the purely combinational sensor-to-output mapping with a light hold timer, a fan with minimum on and off dwell times, and an alarm arming state machine with exit and entry delays. It sits between the synchronized sensor inputs and the actuator drivers. All timing is counted in `tick` enables from the system timebase.

## Interface
- `LIGHT_HOLD`, default 3: ticks the light stays on after the last qualifying motion; must be ≥1.
- `FAN_MIN_ON`, default 4: minimum ticks the fan stays on once started.
- `FAN_MIN_OFF`, default 2: minimum ticks the fan stays off once stopped.
- `EXIT_TICKS`, default 2: arming delay after authorization drops; must be ≥1.
- `ENTRY_TICKS`, default 3: delay from motion while armed to alarm; must be ≥1.
- `CNT_W`, default 8: width of every counter; every tick parameter must be < 2^CNT_W.

Ports:
- `clk` input, 1 bit: the single clock; all logic is rising-edge.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `tick` input, 1 bit: one-cycle timebase enable.
- `pir` input, 1 bit: motion detected, synchronized level.
- `is_dark` input, 1 bit: ambient light below threshold.
- `temp_high` input, 1 bit: temperature above threshold.
- `authorized` input, 1 bit: valid occupant credential present.
- `light_on` output, 1 bit: light drive.
- `fan_on` output, 1 bit: fan drive.
- `alarm_on` output, 1 bit: siren drive.
- `alarm_state` output, 3 bits: current alarm FSM state encoding.

## Operation
**Light** uses hold counter `lcnt`, which takes the first matching rule:
1. `!is_dark`: `lcnt` is set to 0.
2. `pir`: `lcnt` is loaded with LIGHT_HOLD.
3. `tick` and `lcnt!=0`: `lcnt` decrements by 1.
4. Otherwise `lcnt` holds.
- `light_on` is 1 whenever `lcnt!=0`.
- Continued motion keeps retriggering the hold. Darkness ending turns the light off immediately.

**Fan** is an OFF/ON FSM with dwell counter `fcnt`:
- `fcnt` decrements on `tick` while nonzero.
- OFF→ON when `temp_high` and `fcnt==0`; `fcnt` is then loaded with FAN_MIN_ON.
- ON→OFF when `!temp_high` and `fcnt==0`; `fcnt` is then loaded with FAN_MIN_OFF.
- If a load and a tick occur in the same cycle, the load wins.
- `fan_on` is 1 when the FSM is in ON.

**Alarm** FSM states and encodings: DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4. It uses counter `acnt`.
- `authorized=1` in any state goes to DISARMED with `acnt` cleared. This rule has highest priority.
- DISARMED→EXIT when `authorized=0`; `acnt` is cleared.
- In EXIT, `acnt` increments on `tick`, and `pir` is ignored. EXIT→ARMED on the tick where `acnt==EXIT_TICKS-1`.
- ARMED→ENTRY when `pir=1`; `acnt` is cleared.
- In ENTRY, `acnt` increments on `tick`. ENTRY→ALARM on the tick where `acnt==ENTRY_TICKS-1`.
- ALARM is latched until `authorized=1`.
- `alarm_on` is 1 only in ALARM.
- Unused encodings 5–7 recover to DISARMED on the next clock.

## Timing
- Reset values:
  - `lcnt=0`, `fcnt=0`, `acnt=0`.
  - Fan in OFF; alarm FSM in DISARMED.
  - `light_on=0`, `fan_on=0`, `alarm_on=0`, `alarm_state=0`.
- All outputs are decoded from registers, with no combinational input-to-output path.
- Latency is one clock from an input sampled at edge N to the output after edge N. Examples: `pir&is_dark` raises `light_on` one clock later, and `authorized` rising clears `alarm_on` one clock later.
- Reset asserted mid-operation clears all state immediately. After reset is released with `authorized=0`, the FSM enters EXIT on the first clock. The alarm never resumes without a full exit delay.
- `tick` high for more than one cycle counts once per cycle; the bench must not rely on that.
- Counters never wrap: decrement stops at 0, and increments are bounded by the FSM exits.

## Structure
- Shared package `home_pkg` holds:
  - the alarm state encoding constants (DISARMED through ALARM, 3-bit);
  - the fan state constants;
  - the default tick parameter values.
- Natural sub-module: `tick_timer`, a CNT_W-bit loadable down counter with tick enable and a `zero` flag.
  - Instantiated twice: for `lcnt` and `fcnt`.
  - `acnt` stays inline in the alarm FSM, since it counts up and compares against a state-dependent limit.

## Test plan
All scenarios use the default parameters, with `tick` every 4 clocks.
- **Light hold:** `is_dark=1`, `pir` pulse for 1 clock → `light_on=1` next clock, then 0 after exactly the 3rd subsequent tick. A `pir` repulse before then reloads the hold to 3. Dropping `is_dark` clears the light next clock.
- **Fan dwell:** `temp_high` 1 for a single tick then 0 → `fan_on` stays 1 for 4 ticks. Reasserting `temp_high` immediately → fan restarts only after 2 further ticks.
- **Arming:** `authorized` 1→0 → `alarm_state` goes 1, then 2 after 2 ticks. `pir` during EXIT causes no ENTRY.
- **Alarm:** `pir` while ARMED → ENTRY, then ALARM after 3 ticks with `alarm_on=1`. `authorized=1` → `alarm_on=0`, `alarm_state=0` next clock.
- **Entry abort:** `authorized=1` asserted 2 ticks into ENTRY → DISARMED and `alarm_on` never asserts.
- **Reset mid-ALARM:** assert `rst_n=0` while `alarm_on=1` → all outputs 0 asynchronously. Release with `authorized=0` → EXIT, and no alarm before exit plus entry delay. Also force an illegal state (5) and check it recovers to 0.
